// File: rtl/sprite_controller_digits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_controller_digits_pkg
// Description : Shared coordinate width, score-sprite geometry defaults,
//               converter state encoding and elaboration-time helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_controller_digits_pkg;

  // Coordinate width used by the VGA timing generator
  localparam int CORDW = 10;

  // Score-window geometry defaults
  localparam int DEF_SCORE_X    = 0;
  localparam int DEF_SCORE_Y    = 0;
  localparam int DEF_N_DIGITS   = 4;
  localparam int DEF_SCORE_BITS = 14;
  localparam int DEF_GLYPH_W    = 8;
  localparam int DEF_GLYPH_H    = 8;

  // Converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input longint v);
    int     r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of decimal digits needed for the largest value of a bit width
  function automatic int bcd_digits(input int bits);
    longint v;
    int     n;
    v = (longint'(1) << bits) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_controller_digits_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary to BCD converter, one input
//               bit per cycle, with start/busy/done handshake. Values that
//               do not fit in N_DIGITS saturate to all nines.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import sprite_controller_digits_pkg::*;
#(
  parameter int SCORE_BITS = DEF_SCORE_BITS,
  parameter int N_DIGITS   = DEF_N_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SCORE_BITS-1:0]   bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd,
  output logic                    ovf
);

  // Internal BCD register is wide enough for the full input range so that
  // saturation can be detected from the digits above N_DIGITS.
  localparam int FULL_DIG = bcd_digits(SCORE_BITS);
  localparam int NBCD     = (FULL_DIG > N_DIGITS) ? FULL_DIG : N_DIGITS;
  localparam int BW       = 4 * NBCD;
  localparam int CNT_W    = (clog2(SCORE_BITS + 1) > 0) ? clog2(SCORE_BITS + 1) : 1;

  conv_state_e                r_state;
  logic [BW-1:0]              r_bcd;
  logic [SCORE_BITS-1:0]      r_sh;
  logic [CNT_W-1:0]           r_cnt;
  logic [BW-1:0]              w_adj;
  logic [BW+SCORE_BITS-1:0]   w_next;
  logic                       w_hi;

  // Add-3 correction on every nibble >= 5, then shift the whole pair left
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NBCD; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_next = {w_adj, r_sh} << 1;
  end

  // Converter FSM: capture, shift SCORE_BITS times, present result for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bcd   <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_sh    <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd <= w_next[BW+SCORE_BITS-1:SCORE_BITS];
          r_sh  <= w_next[SCORE_BITS-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(SCORE_BITS - 1)) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Any non-zero digit above the displayed ones means the value saturates
  if (NBCD > N_DIGITS) begin : g_sat_hi
    assign w_hi = |r_bcd[BW-1:4*N_DIGITS];
  end else begin : g_sat_none
    assign w_hi = 1'b0;
  end

  assign ovf = w_hi;
  assign bcd = w_hi ? {N_DIGITS{4'h9}} : r_bcd[4*N_DIGITS-1:0];

endmodule
`default_nettype wire

// File: rtl/sprite_controller_digits.sv
`default_nettype none
// ============================================================================
// Module      : sprite_controller_digits
// Description : Multi-digit score sprite. Converts the binary score to BCD,
//               holds it until the next frame start and generates glyph ROM
//               addresses and read enables for the score window.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_controller_digits
  import sprite_controller_digits_pkg::*;
#(
  parameter int  SPR_X      = DEF_SCORE_X,
  parameter int  SPR_Y      = DEF_SCORE_Y,
  parameter int  N_DIGITS   = DEF_N_DIGITS,
  parameter int  SCORE_BITS = DEF_SCORE_BITS,
  parameter int  GLYPH_W    = DEF_GLYPH_W,
  parameter int  GLYPH_H    = DEF_GLYPH_H,
  parameter int  SCALE_LOG2 = 0,
  parameter int  LEAD       = 2,
  parameter int  LZ_BLANK   = 1,
  localparam int ADDR_W     = clog2(10 * GLYPH_W * GLYPH_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CORDW-1:0]      pixel,
  input  logic [CORDW-1:0]      line,
  input  logic [SCORE_BITS-1:0] score,
  input  logic                  score_vld,
  output logic [ADDR_W-1:0]     addr,
  output logic                  rden,
  output logic                  busy,
  output logic                  overflow
);

  localparam int GW_L  = clog2(GLYPH_W);
  localparam int GH_L  = clog2(GLYPH_H);
  localparam int DIG_W = (clog2(N_DIGITS) > 0) ? clog2(N_DIGITS) : 1;
  localparam int XW    = CORDW + 2;

  // Window origin and extent as signed values so SPR_X-LEAD may go negative
  localparam logic signed [XW-1:0] X0    = XW'(SPR_X - LEAD);
  localparam logic signed [XW-1:0] Y0    = XW'(SPR_Y);
  localparam logic signed [XW-1:0] WIN_W = XW'((N_DIGITS * GLYPH_W) << SCALE_LOG2);
  localparam logic signed [XW-1:0] WIN_H = XW'(GLYPH_H << SCALE_LOG2);

  logic                   w_busy;
  logic                   w_done;
  logic                   w_start;
  logic [SCORE_BITS-1:0]  w_bin;
  logic [4*N_DIGITS-1:0]  w_res;
  logic                   w_res_ovf;

  logic [SCORE_BITS-1:0]  r_pin;
  logic                   r_pin_vld;
  logic [4*N_DIGITS-1:0]  r_pend_bcd;
  logic                   r_pend_ovf;
  logic                   r_pend_valid;
  logic [4*N_DIGITS-1:0]  r_disp;
  logic                   r_ovf;

  logic                   w_commit;
  logic [4*N_DIGITS-1:0]  w_disp_eff;
  logic signed [XW-1:0]   w_rx;
  logic signed [XW-1:0]   w_ry;
  logic                   w_win;
  logic [DIG_W-1:0]       w_d;
  logic [GW_L-1:0]        w_col;
  logic [GH_L-1:0]        w_row;
  logic [3:0]             w_dig;
  logic                   w_lz_acc;
  logic                   w_lz_sel;
  logic                   w_blank;
  logic [ADDR_W-1:0]      w_addr;

  // A fresh pulse wins over a parked value; starts only when the converter is idle
  assign w_start = !w_busy && (score_vld || r_pin_vld);
  assign w_bin   = score_vld ? score : r_pin;

  bin2bcd_seq #(
    .SCORE_BITS (SCORE_BITS),
    .N_DIGITS   (N_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (w_bin),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_res),
    .ovf   (w_res_ovf)
  );

  assign busy = w_busy;

  // One-deep parking register for scores that arrive while converting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin     <= '0;
      r_pin_vld <= 1'b0;
    end else if (score_vld && w_busy) begin
      r_pin     <= score;
      r_pin_vld <= 1'b1;
    end else if (w_start) begin
      r_pin_vld <= 1'b0;
    end
  end

  assign w_commit   = (line == '0) && (pixel == '0) && r_pend_valid;
  assign w_disp_eff = w_commit ? r_pend_bcd : r_disp;

  // Pending result and frame-start commit; a coinciding result stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_bcd   <= '0;
      r_pend_ovf   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_disp       <= '0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_commit) begin
        r_disp       <= r_pend_bcd;
        r_ovf        <= r_pend_ovf;
        r_pend_valid <= 1'b0;
      end
      if (w_done) begin
        r_pend_bcd   <= w_res;
        r_pend_ovf   <= w_res_ovf;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign overflow = r_ovf;

  // Window-relative coordinates, digit index, glyph column and row
  always_comb begin
    w_rx  = $signed({2'b00, pixel}) - X0;
    w_ry  = $signed({2'b00, line}) - Y0;
    w_win = !w_rx[XW-1] && (w_rx < WIN_W) && !w_ry[XW-1] && (w_ry < WIN_H);
    w_d   = DIG_W'(w_rx[CORDW-1:0] >> (GW_L + SCALE_LOG2));
    w_col = GW_L'(w_rx[CORDW-1:0] >> SCALE_LOG2);
    w_row = GH_L'(w_ry[CORDW-1:0] >> SCALE_LOG2);
  end

  // Select the digit under the beam and whether it is a leading zero
  always_comb begin
    w_dig    = 4'd0;
    w_lz_sel = 1'b0;
    w_lz_acc = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_lz_acc = w_lz_acc && (w_disp_eff[4*(N_DIGITS-1-i) +: 4] == 4'd0);
      if (w_d == DIG_W'(i)) begin
        w_dig    = w_disp_eff[4*(N_DIGITS-1-i) +: 4];
        w_lz_sel = w_lz_acc;
      end
    end
    w_blank = (LZ_BLANK != 0) && w_lz_sel && (w_d != DIG_W'(N_DIGITS - 1));
    w_addr  = ADDR_W'({w_dig, w_row, w_col});
  end

  // Registered ROM request; the address holds outside the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      rden <= 1'b0;
    end else begin
      rden <= w_win && !w_blank;
      if (w_win) begin
        addr <= w_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_controller_digits.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sprite_controller_digits
// Description : Self-checking bench for the score sprite controller, two
//               instances (unscaled at origin, 2x scaled and offset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_controller_digits;
  import sprite_controller_digits_pkg::*;

  localparam int N = 4, SB = 14, GW = 8, GH = 8, LEAD = 2, AW = 10;
  localparam int SX_A = 0,  SY_A = 0,  SL_A = 0;
  localparam int SX_B = 40, SY_B = 20, SL_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CORDW-1:0] pixel, line;
  logic [SB-1:0] score;
  logic score_vld;
  logic [AW-1:0] addr_a, addr_b;
  logic rden_a, rden_b, busy_a, busy_b, ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  int shown  = 0;

  always #5 clk = ~clk;

  sprite_controller_digits #(.SPR_X(SX_A), .SPR_Y(SY_A), .N_DIGITS(N), .SCORE_BITS(SB),
    .GLYPH_W(GW), .GLYPH_H(GH), .SCALE_LOG2(SL_A), .LEAD(LEAD), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line), .score(score),
    .score_vld(score_vld), .addr(addr_a), .rden(rden_a), .busy(busy_a), .overflow(ovf_a));

  sprite_controller_digits #(.SPR_X(SX_B), .SPR_Y(SY_B), .N_DIGITS(N), .SCORE_BITS(SB),
    .GLYPH_W(GW), .GLYPH_H(GH), .SCALE_LOG2(SL_B), .LEAD(LEAD), .LZ_BLANK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel(pixel), .line(line), .score(score),
    .score_vld(score_vld), .addr(addr_b), .rden(rden_b), .busy(busy_b), .overflow(ovf_b));

  // Reference: decimal arithmetic on the shown value, division for geometry
  function automatic void model(input int px, input int ln, input int v, input int sx,
                                input int sy, input int sl, output bit e_win,
                                output bit e_rden, output int e_addr);
    int rx, ry, sc, d, p10;
    sc = 1 << sl;
    rx = px - (sx - LEAD);
    ry = ln - sy;
    e_win  = (rx >= 0) && (rx < N * GW * sc) && (ry >= 0) && (ry < GH * sc);
    e_rden = 1'b0;
    e_addr = 0;
    if (e_win) begin
      d   = rx / (GW * sc);
      p10 = 1;
      for (int k = 0; k < N - 1 - d; k++) p10 = p10 * 10;
      e_addr = ((v / p10) % 10) * GW * GH + (ry / sc) * GW + ((rx / sc) % GW);
      e_rden = !((v < p10) && (d != N - 1));
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    pixel = CORDW'(1000);
    line  = CORDW'(1000);
  endtask

  task automatic frame_start();
    pixel = '0;
    line  = '0;
    step();
    park();
  endtask

  task automatic convert(input int v, output int busy_cycles);
    score = SB'(v);
    score_vld = 1'b1;
    step();
    score_vld = 1'b0;
    busy_cycles = 0;
    while (busy_a && busy_cycles < 200) begin
      busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    score_vld = 1'b0;
    score = '0;
    park();
    step(); step();
    checks++; if (addr_a !== '0) begin errors++; $display("FAIL reset_addr_a got %0d exp 0", addr_a); end
    checks++; if (rden_a !== 1'b0) begin errors++; $display("FAIL reset_rden_a got %0b exp 0", rden_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %0b exp 0", busy_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf_a got %0b exp 0", ovf_a); end
    checks++; if (addr_b !== '0 || rden_b !== 1'b0) begin errors++; $display("FAIL reset_b got addr %0d rden %0b exp 0 0", addr_b, rden_b); end
    rst_n = 1'b1;
    step();
    shown = 0;
  endtask

  task automatic test_blank_zero();
    bit ew, er; int ea;
    for (int ln = 0; ln < 10; ln += 3) begin
      for (int px = 1; px < 34; px++) begin
        pixel = CORDW'(px); line = CORDW'(ln);
        step();
        model(px, ln, shown, SX_A, SY_A, SL_A, ew, er, ea);
        checks++; if (rden_a !== er) begin errors++; $display("FAIL zero_rden px=%0d ln=%0d got %0b exp %0b", px, ln, rden_a, er); end
        if (ew) begin checks++; if (addr_a !== AW'(ea)) begin errors++; $display("FAIL zero_addr px=%0d ln=%0d got %0d exp %0d", px, ln, addr_a, ea); end end
      end
    end
    park();
  endtask

  task automatic test_convert();
    bit ew, er; int ea, bc;
    convert(1234, bc);
    checks++; if (bc != SB + 1) begin errors++; $display("FAIL busy_len got %0d exp %0d", bc, SB + 1); end
    // Not yet on screen: no frame start has occurred
    for (int px = 1; px < 34; px++) begin
      pixel = CORDW'(px); line = CORDW'(3);
      step();
      model(px, 3, shown, SX_A, SY_A, SL_A, ew, er, ea);
      checks++; if (rden_a !== er || (ew && addr_a !== AW'(ea))) begin errors++; $display("FAIL hold_frame px=%0d got %0d/%0b exp %0d/%0b", px, addr_a, rden_a, ea, er); end
    end
    park();
    // Frame start on a non-zero line must not commit
    pixel = '0; line = CORDW'(5); step(); park();
    pixel = CORDW'(6); line = CORDW'(1); step();
    checks++; if (addr_a !== AW'(8)) begin errors++; $display("FAIL no_commit_line got %0d exp 8", addr_a); end
    frame_start();
    shown = 1234;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_1234 got %0b exp 0", ovf_a); end
    for (int ln = 0; ln < 8; ln += 7) begin
      for (int px = 1; px < 34; px++) begin
        pixel = CORDW'(px); line = CORDW'(ln);
        step();
        model(px, ln, shown, SX_A, SY_A, SL_A, ew, er, ea);
        checks++; if (rden_a !== er) begin errors++; $display("FAIL s1234_rden px=%0d ln=%0d got %0b exp %0b", px, ln, rden_a, er); end
        if (ew) begin checks++; if (addr_a !== AW'(ea)) begin errors++; $display("FAIL s1234_addr px=%0d ln=%0d got %0d exp %0d", px, ln, addr_a, ea); end end
      end
    end
    park();
  endtask

  task automatic test_overflow();
    bit ew, er; int ea, bc;
    convert(12000, bc);
    checks++; if (bc != SB + 1) begin errors++; $display("FAIL ovf_busy_len got %0d exp %0d", bc, SB + 1); end
    frame_start();
    shown = 9999;
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_a got %0b exp 1", ovf_a); end
    checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_b got %0b exp 1", ovf_b); end
    for (int px = 1; px < 34; px++) begin
      pixel = CORDW'(px); line = CORDW'(5);
      step();
      model(px, 5, shown, SX_A, SY_A, SL_A, ew, er, ea);
      checks++; if (rden_a !== er || (ew && addr_a !== AW'(ea))) begin errors++; $display("FAIL sat px=%0d got %0d/%0b exp %0d/%0b", px, addr_a, rden_a, ea, er); end
    end
    park();
  endtask

  task automatic test_back_to_back();
    bit ew, er; int ea, nb;
    nb = 0;
    score = SB'(5); score_vld = 1'b1; step(); score_vld = 1'b0; nb += busy_a;
    step(); nb += busy_a;
    step(); nb += busy_a;
    score = SB'(7); score_vld = 1'b1; step(); score_vld = 1'b0; nb += busy_a;
    for (int i = 0; i < 60; i++) begin step(); nb += busy_a; end
    checks++; if (nb != 2 * (SB + 1)) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp %0d", nb, 2 * (SB + 1)); end
    frame_start();
    shown = 7;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %0b exp 0", ovf_a); end
    for (int px = 1; px < 34; px++) begin
      pixel = CORDW'(px); line = CORDW'(4);
      step();
      model(px, 4, shown, SX_A, SY_A, SL_A, ew, er, ea);
      checks++; if (rden_a !== er || (ew && addr_a !== AW'(ea))) begin errors++; $display("FAIL b2b px=%0d got %0d/%0b exp %0d/%0b", px, addr_a, rden_a, ea, er); end
    end
    park();
  endtask

  task automatic test_random();
    bit ew, er; int ea, bc, v, px, ln;
    for (int k = 0; k < 6; k++) begin
      v = (k == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, (1 << SB) - 1));
      convert(v, bc);
      checks++; if (bc != SB + 1) begin errors++; $display("FAIL rnd_busy v=%0d got %0d exp %0d", v, bc, SB + 1); end
      frame_start();
      shown = (v > 9999) ? 9999 : v;
      checks++; if (ovf_a !== (v > 9999)) begin errors++; $display("FAIL rnd_ovf v=%0d got %0b exp %0b", v, ovf_a, (v > 9999)); end
      for (int j = 0; j < 24; j++) begin
        px = $urandom_range(0, 34);
        ln = $urandom_range(0, 9);
        if (px == 0 && ln == 0) px = 1;
        pixel = CORDW'(px); line = CORDW'(ln);
        step();
        model(px, ln, shown, SX_A, SY_A, SL_A, ew, er, ea);
        checks++; if (rden_a !== er || (ew && addr_a !== AW'(ea))) begin errors++; $display("FAIL rnd_a v=%0d px=%0d ln=%0d got %0d/%0b exp %0d/%0b", v, px, ln, addr_a, rden_a, ea, er); end
        px = $urandom_range(36, 103);
        ln = $urandom_range(18, 37);
        pixel = CORDW'(px); line = CORDW'(ln);
        step();
        model(px, ln, shown, SX_B, SY_B, SL_B, ew, er, ea);
        checks++; if (rden_b !== er || (ew && addr_b !== AW'(ea))) begin errors++; $display("FAIL rnd_b v=%0d px=%0d ln=%0d got %0d/%0b exp %0d/%0b", v, px, ln, addr_b, rden_b, ea, er); end
      end
      park();
    end
  endtask

  task automatic test_scale();
    bit ew, er; int ea, bc;
    convert(305, bc);
    frame_start();
    shown = 305;
    checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL scale_ovf got %0b exp 0", ovf_b); end
    for (int ln = 19; ln < 37; ln += 8) begin
      for (int px = 36; px < 104; px++) begin
        pixel = CORDW'(px); line = CORDW'(ln);
        step();
        model(px, ln, shown, SX_B, SY_B, SL_B, ew, er, ea);
        checks++; if (rden_b !== er) begin errors++; $display("FAIL scale_rden px=%0d ln=%0d got %0b exp %0b", px, ln, rden_b, er); end
        if (ew) begin checks++; if (addr_b !== AW'(ea)) begin errors++; $display("FAIL scale_addr px=%0d ln=%0d got %0d exp %0d", px, ln, addr_b, ea); end end
      end
    end
    park();
  endtask

  task automatic test_reset_mid_conv();
    bit ew, er; int ea;
    score = SB'(4321); score_vld = 1'b1; step(); score_vld = 1'b0;
    pixel = CORDW'(10); line = CORDW'(1);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #2;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b exp 0", busy_a); end
    checks++; if (addr_a !== '0 || rden_a !== 1'b0) begin errors++; $display("FAIL rst_mid_out got %0d/%0b exp 0/0", addr_a, rden_a); end
    park();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_discard_busy got %0b exp 0", busy_a); end
    frame_start();
    shown = 0;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", ovf_a); end
    for (int px = 1; px < 34; px++) begin
      pixel = CORDW'(px); line = CORDW'(1);
      step();
      model(px, 1, shown, SX_A, SY_A, SL_A, ew, er, ea);
      checks++; if (rden_a !== er || (ew && addr_a !== AW'(ea))) begin errors++; $display("FAIL rst_digits px=%0d got %0d/%0b exp %0d/%0b", px, addr_a, rden_a, ea, er); end
    end
    park();
  endtask

  initial begin
    test_reset();
    test_blank_zero();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_random();
    test_scale();
    test_reset_mid_conv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_controller_digits.md
# sprite_controller_digits

Parametrised multi-digit score sprite controller. Converts a binary score to decimal, holds it tear-free until the next frame start, and generates a font-ROM read address and read enable for each pixel inside the score window. It sits between game logic (score source), the VGA timing generator (`pixel`/`line`), and a shared digit-glyph ROM (glyphs 0–9 stored consecutively, row-major). It supports N digits, integer pixel scaling and optional leading-zero blanking.

## Interface
Parameters:
- `SPR_X`, 0: left x of the score window.
- `SPR_Y`, 0: top y of the score window.
- `N_DIGITS`, 4: number of displayed decimal digits, 1..6.
- `SCORE_BITS`, 14: width of the binary score input.
- `GLYPH_W`, 8: glyph width in ROM pixels; must be a power of 2.
- `GLYPH_H`, 8: glyph height in ROM pixels; must be a power of 2.
- `SCALE_LOG2`, 0: on-screen scale is 2^SCALE_LOG2.
- `LEAD`, 2: pixels that `rden` precedes the visible pixel, to cover ROM plus pipeline latency.
- `LZ_BLANK`, 1: when 1, leading zeros are not read. The least significant digit is always shown.

Ports (`ADDR_W` = clog2(10·GLYPH_W·GLYPH_H)):
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pixel` in `CORDW`: current x coordinate.
- `line` in `CORDW`: current y coordinate.
- `score` in SCORE_BITS: binary score.
- `score_vld` in 1: one-cycle pulse that loads `score`.
- `addr` out ADDR_W: glyph ROM address, registered.
- `rden` out 1: ROM read enable, registered.
- `busy` out 1: a conversion is in progress.
- `overflow` out 1: the displayed value is saturated.

## Operation
- Converter FSM with three states: IDLE, CONV, DONE.
  - IDLE → CONV on `score_vld`. The FSM captures `score` into the shift register and clears the BCD register.
  - CONV runs double-dabble for SCORE_BITS cycles, one bit per cycle: add 3 to every nibble ≥5, then shift left.
  - CONV → DONE after the last bit. DONE writes `pend_bcd` and sets `pend_valid`, then → IDLE.
- Saturation: if the value exceeds 10^N_DIGITS−1, `pend_bcd` is all 9s and `pend_ovf`=1.
- `score_vld` while `busy`: the value goes into a one-deep pending-input register, newest wins. It starts a conversion on the cycle after DONE.
- Commit: the display digit registers and `overflow` load from `pend_*` only when `line`==0 && `pixel`==0 && `pend_valid`. `pend_valid` clears on commit. If a conversion and a commit coincide, the commit uses the old pend value.
- Window: `win` = `pixel` ∈ [SPR_X−LEAD, SPR_X−LEAD + N_DIGITS·GLYPH_W·2^S − 1] and `line` ∈ [SPR_Y, SPR_Y + GLYPH_H·2^S − 1]. S = SCALE_LOG2.
- Inside the window:
  - rx = `pixel`−(SPR_X−LEAD); ry = `line`−SPR_Y.
  - d = rx >> (log2 GLYPH_W + S), where 0 is the most significant digit.
  - col = (rx>>S) mod GLYPH_W; row = ry>>S.
  - All shifts and masks only; no dividers.
- Address: `addr` = dig[d]·GLYPH_W·GLYPH_H + row·GLYPH_W + col, truncated to ADDR_W.
- Blanking: `rden` = `win` && !(LZ_BLANK && d is a leading zero && d≠N_DIGITS−1). Outside the window `addr` holds its last value.

## Timing
- Reset values: `addr`=0, `rden`=0, `busy`=0, `overflow`=0, all digits 0, `pend_valid`=0, FSM in IDLE.
- Reset mid-conversion aborts the conversion and discards pending input.
- `addr` and `rden` are registered 1 cycle after the `pixel`/`line` they correspond to.
- `busy` rises the cycle after `score_vld` and is high for SCORE_BITS+1 cycles.
- Latency from `score_vld` to `pend_valid` is SCORE_BITS+2 cycles. On-screen update happens at the next frame start after that.
- A digit value never changes within a frame.

## Structure
- `CORDW` comes from the shared define.v.
- Add `SCORE_Y`/digit geometry defaults, glyph size, and the clog2 helper function to the shared package.
- One sub-module: `bin2bcd_seq`, the sequential double-dabble with a start/busy/done handshake. It is parametrised by SCORE_BITS and N_DIGITS and owns the saturation logic.

## Test plan
- Reset, then no score: `rden` is high only for the last digit (LZ_BLANK=1). `addr` runs 0..7 per row of glyph 0; `overflow`=0.
- `score`=1234, N_DIGITS=4, GLYPH 8×8: `busy` high for 15 cycles. Digits appear on the next frame. First window pixel gives `addr`=64 (glyph 1, row 0, col 0); digit 3 starts at `addr`=256.
- `score`=12000 with N_DIGITS=4: display shows 9999 and `overflow`=1 after the frame start.
- Two `score_vld` pulses (5 then 7) 3 cycles apart: first conversion completes, then 7 converts. The frame shows 7, never 5, if both finish before frame start.
- SCALE_LOG2=1: each `addr` is held for 2 consecutive pixels and each row for 2 lines. The window is 64 pixels wide per digit pair of 8 cols.
- Assert `rst_n` low mid-CONV: `busy` goes to 0 immediately and `addr`/`rden` go to 0. The displayed digits are 0 after reset.
